// File: rtl/sys_bus_arbiter.sv
// Two-master, four-slave bus arbiter and address decoder: m1 has fixed priority and one
// transaction is in flight at a time. Each grant ends in exactly one ack (done, unmapped or timeout).
module sys_bus_arbiter #(
    parameter int SLAVE_NUM = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m0_req_in,
    input  logic [31:0]               m0_addr_in,
    input  logic [31:0]               m0_data_in,
    input  logic                      m0_rw_in,
    output logic [31:0]               m0_data_out,
    output logic [1:0]                m0_select_as_out,
    output logic                      m0_ack_out,
    input  logic                      m1_req_in,
    input  logic [31:0]               m1_addr_in,
    input  logic [31:0]               m1_data_in,
    input  logic                      m1_rw_in,
    output logic [31:0]               m1_data_out,
    output logic [1:0]                m1_select_as_out,
    output logic                      m1_ack_out,
    output logic [31:0]               s_addr_out,
    output logic [31:0]               s_data_out,
    output logic [2*SLAVE_NUM-1:0]    s_select_as_out,
    input  logic [32*SLAVE_NUM-1:0]   s_data_in,
    input  logic [SLAVE_NUM-1:0]      s_ready_in,
    output logic                      hold_flag_out,
    output logic                      err_out
);

    localparam int SEL_W = 2 * SLAVE_NUM;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_rw;
    logic               r_mid;
    logic               r_err;
    logic [7:0]         r_cnt;
    logic [SEL_W-1:0]   r_s_sel;
    logic [1:0]         r_m0_sel;
    logic [1:0]         r_m1_sel;
    logic               r_m0_ack;
    logic               r_m1_ack;
    logic [31:0]        r_m0_data;
    logic [31:0]        r_m1_data;

    logic [1:0]         w_slv;
    logic               w_rdy;
    logic [31:0]        w_rdata;
    logic               w_timeout;
    logic [31:0]        w_fin_data;
    logic               w_req_any;
    logic               w_gnt_id;
    logic [31:0]        w_gnt_addr;
    logic [31:0]        w_gnt_wdata;
    logic               w_gnt_rw;
    logic [1:0]         w_gnt_mode;
    logic               w_gnt_unmapped;
    logic [SEL_W-1:0]   w_gnt_sel;

    // Only the addressed slave's ready and read data are looked at.
    assign w_slv      = r_addr[29:28];
    assign w_rdy      = s_ready_in[w_slv];
    assign w_rdata    = s_data_in[32*w_slv +: 32];
    assign w_timeout  = (r_cnt == 8'(TIMEOUT - 1));
    assign w_fin_data = (w_rdy && !r_rw) ? w_rdata : 32'd0;

    assign w_req_any      = m0_req_in | m1_req_in;
    assign w_gnt_id       = m1_req_in;
    assign w_gnt_addr     = m1_req_in ? m1_addr_in : m0_addr_in;
    assign w_gnt_wdata    = m1_req_in ? m1_data_in : m0_data_in;
    assign w_gnt_rw       = m1_req_in ? m1_rw_in   : m0_rw_in;
    assign w_gnt_mode     = w_gnt_rw ? 2'b10 : 2'b01;
    assign w_gnt_unmapped = |w_gnt_addr[31:30];
    assign w_gnt_sel      = SEL_W'(w_gnt_mode) << {w_gnt_addr[29:28], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rw      <= 1'b0;
            r_mid     <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_s_sel   <= '0;
            r_m0_sel  <= '0;
            r_m1_sel  <= '0;
            r_m0_ack  <= 1'b0;
            r_m1_ack  <= 1'b0;
            r_m0_data <= '0;
            r_m1_data <= '0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_addr  <= w_gnt_addr;
                        r_wdata <= w_gnt_wdata;
                        r_rw    <= w_gnt_rw;
                        r_mid   <= w_gnt_id;
                        r_cnt   <= '0;
                        if (w_gnt_unmapped) begin
                            // Unmapped: skip the slave bus and answer with an error at once.
                            r_state <= RESP;
                            r_err   <= 1'b1;
                            if (w_gnt_id) begin
                                r_m1_ack  <= 1'b1;
                                r_m1_data <= '0;
                            end else begin
                                r_m0_ack  <= 1'b1;
                                r_m0_data <= '0;
                            end
                        end else begin
                            r_state <= ACCESS;
                            r_s_sel <= w_gnt_sel;
                            if (w_gnt_id) r_m1_sel <= w_gnt_mode;
                            else          r_m0_sel <= w_gnt_mode;
                        end
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 8'd1;
                    // Ready wins over timeout when both land in the same cycle.
                    if (w_rdy || w_timeout) begin
                        r_state  <= RESP;
                        r_err    <= !w_rdy;
                        r_s_sel  <= '0;
                        r_m0_sel <= '0;
                        r_m1_sel <= '0;
                        if (r_mid) begin
                            r_m1_ack  <= 1'b1;
                            r_m1_data <= w_fin_data;
                        end else begin
                            r_m0_ack  <= 1'b1;
                            r_m0_data <= w_fin_data;
                        end
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_addr_out       = (r_state == ACCESS) ? r_addr  : 32'd0;
    assign s_data_out       = (r_state == ACCESS) ? r_wdata : 32'd0;
    assign s_select_as_out  = r_s_sel;
    assign m0_select_as_out = r_m0_sel;
    assign m1_select_as_out = r_m1_sel;
    assign m0_ack_out       = r_m0_ack;
    assign m1_ack_out       = r_m1_ack;
    assign m0_data_out      = r_m0_data;
    assign m1_data_out      = r_m1_data;
    assign err_out          = r_err;
    assign hold_flag_out    = m0_req_in & ~r_m0_ack;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: directed scenarios plus randomized single-master transactions
// whose ack cycle, error and data come from a transaction-level latency model.
module tb_sys_bus_arbiter;

    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req_in, m0_rw_in, m1_req_in, m1_rw_in;
    logic [31:0]   m0_addr_in, m0_data_in, m1_addr_in, m1_data_in;
    logic [31:0]   m0_data_out, m1_data_out;
    logic [1:0]    m0_select_as_out, m1_select_as_out;
    logic          m0_ack_out, m1_ack_out;
    logic [31:0]   s_addr_out, s_data_out;
    logic [7:0]    s_select_as_out;
    logic [127:0]  s_data_in;
    logic [3:0]    s_ready_in;
    logic          hold_flag_out, err_out;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_data [2];
    logic          exp_valid [2];

    sys_bus_arbiter #(.SLAVE_NUM(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req_in(m0_req_in), .m0_addr_in(m0_addr_in), .m0_data_in(m0_data_in),
        .m0_rw_in(m0_rw_in), .m0_data_out(m0_data_out),
        .m0_select_as_out(m0_select_as_out), .m0_ack_out(m0_ack_out),
        .m1_req_in(m1_req_in), .m1_addr_in(m1_addr_in), .m1_data_in(m1_data_in),
        .m1_rw_in(m1_rw_in), .m1_data_out(m1_data_out),
        .m1_select_as_out(m1_select_as_out), .m1_ack_out(m1_ack_out),
        .s_addr_out(s_addr_out), .s_data_out(s_data_out),
        .s_select_as_out(s_select_as_out), .s_data_in(s_data_in),
        .s_ready_in(s_ready_in), .hold_flag_out(hold_flag_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_master(input int m, input logic req, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic rw);
        if (m != 0) begin
            m1_req_in = req; m1_addr_in = addr; m1_data_in = wdata; m1_rw_in = rw;
        end else begin
            m0_req_in = req; m0_addr_in = addr; m0_data_in = wdata; m0_rw_in = rw;
        end
    endtask

    // One transaction from master m; waitst = cycles the addressed slave withholds ready.
    task automatic run_txn(input int m, input logic [31:0] addr, input logic rw,
                           input logic [31:0] wdata, input int waitst, input logic [31:0] rdata);
        int          exp_cyc, sl, o;
        logic        exp_err, unm, in_acc;
        logic [31:0] exp_d;
        logic [1:0]  mode;
        logic [3:0]  rnd;
        o    = 1 - m;
        unm  = (addr[31:30] != 2'b00);
        sl   = int'(addr[29:28]);
        mode = rw ? 2'b10 : 2'b01;
        if (unm) begin
            exp_cyc = 1; exp_err = 1'b1; exp_d = 32'd0;
        end else if (waitst <= TIMEOUT - 1) begin
            exp_cyc = waitst + 2; exp_err = 1'b0; exp_d = rdata;
        end else begin
            exp_cyc = TIMEOUT + 1; exp_err = 1'b1; exp_d = 32'd0;
        end
        drive_master(m, 1'b1, addr, wdata, rw);
        for (int i = 0; i < 4; i++) s_data_in[32*i +: 32] = $urandom;
        s_data_in[32*sl +: 32] = rdata;
        for (int c = 0; c <= exp_cyc; c++) begin
            rnd = 4'($urandom);
            rnd[sl] = (c == waitst + 1);
            s_ready_in = rnd;
            @(negedge clk);
            in_acc = !unm && (c >= 1) && (c < exp_cyc);
            check("ack", 32'((m != 0) ? m1_ack_out : m0_ack_out), 32'(c == exp_cyc));
            check("other_ack", 32'((m != 0) ? m0_ack_out : m1_ack_out), 32'd0);
            check("err", 32'(err_out), 32'((c == exp_cyc) ? exp_err : 1'b0));
            check("s_sel", 32'(s_select_as_out), in_acc ? 32'(8'(mode) << (2 * sl)) : 32'd0);
            check("m_sel", 32'((m != 0) ? m1_select_as_out : m0_select_as_out),
                  in_acc ? 32'(mode) : 32'd0);
            check("other_sel", 32'((m != 0) ? m0_select_as_out : m1_select_as_out), 32'd0);
            check("hold", 32'(hold_flag_out), 32'((m == 0) && (c != exp_cyc)));
            if (in_acc) begin
                check("s_addr", s_addr_out, addr);
                if (rw) check("s_wdata", s_data_out, wdata);
            end
            if (exp_valid[o]) check("other_data", (o != 0) ? m1_data_out : m0_data_out, exp_data[o]);
            if (c == exp_cyc) begin
                if (!rw || exp_err) begin
                    check("rdata", (m != 0) ? m1_data_out : m0_data_out, exp_d);
                    exp_data[m]  = exp_d;
                    exp_valid[m] = 1'b1;
                end else begin
                    exp_valid[m] = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        drive_master(m, 1'b0, 32'd0, 32'd0, 1'b0);
        s_ready_in = 4'd0;
    endtask

    initial begin
        rst = 1'b1;
        drive_master(0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive_master(1, 1'b0, 32'd0, 32'd0, 1'b0);
        s_data_in  = '0;
        s_ready_in = '0;
        exp_data[0] = 32'd0; exp_data[1] = 32'd0;
        exp_valid[0] = 1'b1; exp_valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack0", 32'(m0_ack_out), 32'd0);
        check("rst_ack1", 32'(m1_ack_out), 32'd0);
        check("rst_sel", 32'(s_select_as_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        check("rst_data0", m0_data_out, 32'd0);
        check("rst_hold", 32'(hold_flag_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed scenarios.
        run_txn(0, 32'h1000_0040, 1'b0, 32'd0, 0, 32'hDEAD_BEEF);
        run_txn(0, 32'h3000_0000, 1'b1, 32'h1234_5678, 3, 32'd0);

        // Simultaneous requests: m1 first, m0 on the following IDLE.
        drive_master(0, 1'b1, 32'h0000_0020, 32'd0, 1'b0);
        drive_master(1, 1'b1, 32'h0000_0010, 32'd0, 1'b0);
        s_ready_in = 4'b0001;
        for (int c = 0; c <= 5; c++) begin
            s_data_in[31:0] = 32'hA000_0000 + 32'(c);
            @(negedge clk);
            check("sim_ack1", 32'(m1_ack_out), 32'(c == 2));
            check("sim_ack0", 32'(m0_ack_out), 32'(c == 5));
            check("sim_hold", 32'(hold_flag_out), 32'(c <= 4));
            check("sim_m0sel", 32'(m0_select_as_out), 32'((c == 4) ? 2'b01 : 2'b00));
            if (c == 2) check("sim_data1", m1_data_out, 32'hA000_0001);
            if (c == 5) check("sim_data0", m0_data_out, 32'hA000_0004);
            @(posedge clk); #1;
            if (c == 2) drive_master(1, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        drive_master(0, 1'b0, 32'd0, 32'd0, 1'b0);
        s_ready_in = 4'd0;
        exp_data[0] = 32'hA000_0004; exp_data[1] = 32'hA000_0001;
        exp_valid[0] = 1'b1; exp_valid[1] = 1'b1;

        run_txn(0, 32'h8000_0000, 1'b0, 32'd0, 0, 32'h5555_5555);
        run_txn(0, 32'h2000_0000, 1'b0, 32'd0, 100, 32'h7777_7777);
        run_txn(1, 32'h0000_0100, 1'b0, 32'd0, TIMEOUT - 1, 32'hCAFE_0001);
        run_txn(1, 32'h1000_0100, 1'b1, 32'hBEEF_0002, TIMEOUT, 32'd0);

        // Reset during a slave1 access with ready withheld.
        drive_master(0, 1'b1, 32'h1000_0000, 32'd0, 1'b0);
        s_ready_in = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_ack_c2", 32'(m0_ack_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_master(0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("rstmid_ack", 32'(m0_ack_out), 32'd0);
        check("rstmid_sel", 32'(s_select_as_out), 32'd0);
        check("rstmid_msel", 32'(m0_select_as_out), 32'd0);
        check("rstmid_err", 32'(err_out), 32'd0);
        check("rstmid_data0", m0_data_out, 32'd0);
        check("rstmid_data1", m1_data_out, 32'd0);
        check("rstmid_saddr", s_addr_out, 32'd0);
        exp_data[0] = 32'd0; exp_data[1] = 32'd0;
        @(posedge clk); #1;
        run_txn(0, 32'h1000_0008, 1'b0, 32'd0, 1, 32'h0BAD_F00D);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[31:30] = 2'b00;
            run_txn(int'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom,
                    int'($urandom_range(0, TIMEOUT + 2)), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
